pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and safe control-bundle constants for the inter-stage pipeline registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of a stage register: nothing held, main entry held, main and skid entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Control bundle layout shared by all stages (16 bits).
  typedef struct packed {
    logic [6:0] rsvd;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam logic [3:0] ALU_OP_NONE = 4'h0;
  localparam logic [3:0] ALU_OP_NOP  = 4'hF;

  // A bundle with every side-effecting bit cleared; only the ALU opcode is chosen per stage.
  function automatic ctrl_t safe_ctrl(input logic [3:0] alu_op);
    ctrl_t c;
    c           = '0;
    c.alu_op    = alu_op;
    return c;
  endfunction

  // Safe control bundles presented by each stage register while it is empty.
  localparam ctrl_t CTRL_SAFE_IFID  = safe_ctrl(ALU_OP_NONE);
  localparam ctrl_t CTRL_SAFE_IDEX  = safe_ctrl(ALU_OP_NOP);
  localparam ctrl_t CTRL_SAFE_EXMEM = safe_ctrl(ALU_OP_NOP);
  localparam ctrl_t CTRL_SAFE_MEMWB = safe_ctrl(ALU_OP_NONE);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage bubble statistics.
// Latency: count reflects an increment one cycle after inc is high.
// Backpressure: none; sticks at all-ones until reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment on request, stop at the maximum value, clear only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with optional skid entry, flush, hold and bubble counting.
// Latency: an accepted payload is presented on out_* the following cycle; order is preserved.
// Backpressure: SKID=1 gives a registered in_ready (two entries); SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter int                 CTRL_W    = 16,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  NOP_DATA  = '0,
  parameter logic [CTRL_W-1:0]  CTRL_SAFE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import pipe_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic active;
  logic accept;
  logic drain;

  // The stage neither accepts nor presents while held or flushed.
  assign active = !hold && !flush;

  if (SKID != 0) begin : g_rdy_skid
    // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
    assign in_ready = reset && active && (state_q != ST_TWO);
  end else begin : g_rdy_single
    // A single entry can be refilled in the same cycle it drains.
    assign in_ready = reset && active && ((state_q == ST_EMPTY) || out_ready);
  end

  assign out_valid = (state_q != ST_EMPTY) && active;
  assign out_data  = out_valid ? main_data_q : NOP_DATA;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_SAFE;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Occupancy and payload next-state: flush beats hold, hold freezes everything.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_SAFE;
      skid_ctrl_d = CTRL_SAFE;
    end else if (!hold) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (drain) begin
            state_d     = ST_EMPTY;
          end else if (accept && (SKID != 0)) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; a reset drops every held entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= NOP_DATA;
      main_ctrl_q <= CTRL_SAFE;
      skid_data_q <= NOP_DATA;
      skid_ctrl_q <= CTRL_SAFE;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share the stimulus.
// Each instance has a queue-based occupancy model; a monitor pops it on every downstream transfer.
// Directed sequences (stream, back-pressure, flush, hold, async reset) followed by random traffic.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int              DW     = 64;
  localparam int              CW     = 16;
  localparam logic [DW-1:0]   NOP_D  = 64'h0000_0000_0000_0013;
  localparam logic [CW-1:0]   SAFE_C = CTRL_SAFE_IDEX;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          hold = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SK  = (g == 0) ? 1 : 0;
    localparam int CNW = (g == 0) ? 16 : 2;
    localparam int MAXB = (1 << CNW) - 1;

    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  out_ctrl;
    logic [CNW-1:0] bubble_cnt;

    item_t sbq[$];
    int    exp_bub = 0;

    pipe_stage_reg #(
      .DATA_W    (DW),
      .CTRL_W    (CW),
      .SKID      (SK),
      .NOP_DATA  (NOP_D),
      .CTRL_SAFE (SAFE_C),
      .CNT_W     (CNW)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .hold       (hold),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .bubble_cnt (bubble_cnt)
    );

    // Per-cycle handshake prediction from queue occupancy; pushes accepted items.
    initial begin
      forever begin
        @(posedge clk);
        #2;
        if (!reset) begin
          chk($sformatf("rst_in_ready%0d", g), 64'(in_ready), 64'd0);
          chk($sformatf("rst_out_valid%0d", g), 64'(out_valid), 64'd0);
          chk($sformatf("rst_bubble%0d", g), 64'(bubble_cnt), 64'd0);
          sbq.delete();
          exp_bub = 0;
        end else begin
          bit    er;
          bit    ev;
          item_t it;
          int    cap;
          cap = (SK != 0) ? 2 : 1;
          er  = !hold && !flush && ((sbq.size() < cap) || (SK == 0 && out_ready));
          ev  = (sbq.size() > 0) && !hold && !flush;
          chk($sformatf("in_ready%0d", g), 64'(in_ready), 64'(er));
          chk($sformatf("out_valid%0d", g), 64'(out_valid), 64'(ev));
          chk($sformatf("bubble%0d", g), 64'(bubble_cnt), 64'(exp_bub));
          if (flush) begin
            sbq.delete();
          end else if (in_valid && er) begin
            it.d = in_data;
            it.c = in_ctrl;
            sbq.push_back(it);
          end
          if (!ev && exp_bub < MAXB) exp_bub++;
        end
      end
    end

    // Monitor: every downstream transfer must match the oldest expected item.
    initial begin
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out%0d got=%h want=none", g, out_data);
          end else begin
            item_t it;
            it = sbq.pop_front();
            chk($sformatf("out_data%0d", g), out_data, it.d);
            chk($sformatf("out_ctrl%0d", g), 64'(out_ctrl), 64'(it.c));
          end
        end else if (!out_valid) begin
          chk($sformatf("nop_data%0d", g), out_data, NOP_D);
          chk($sformatf("safe_ctrl%0d", g), 64'(out_ctrl), 64'(SAFE_C));
        end
      end
    end

    // An asynchronous reset must clear the outputs without waiting for a clock edge.
    initial begin
      forever begin
        @(negedge reset);
        #1;
        chk($sformatf("arst_out_valid%0d", g), 64'(out_valid), 64'd0);
        chk($sformatf("arst_in_ready%0d", g), 64'(in_ready), 64'd0);
        chk($sformatf("arst_bubble%0d", g), 64'(bubble_cnt), 64'd0);
      end
    end
  end

  task automatic drive(input bit f, input bit h, input bit v, input bit r, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    flush     = f;
    hold      = h;
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    in_ctrl   = CW'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Back-to-back stream with downstream always ready.
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, DW'(i));
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Back-pressure fills the stage, then release drains in order.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hA);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hB);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Flush while full with a valid input in the same cycle.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hA1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hB1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'hC1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Hold for three cycles with one entry, then release.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hA2);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 64'hEE);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Flush and hold together: flush wins.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hA3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hC3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Asynchronous reset mid-stream with the skid stage full.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hA4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'hB4);
    @(posedge clk);
    #3;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'hD4);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'hD5);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;

    // Idle long enough for the narrow counter to saturate.
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 20) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, {$urandom, $urandom});
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
